int_square: RTL and testbench
=============================

Name: int_square

Overview:
- Iterative integer squarer: given `root`, computes `square = root*root`.
- Inverse direction of the integer square-root unit in the same design. The sqrt side consumes consecutive odd numbers; this block accumulates them: root² = 1+3+5+…+(2·root−1).
- Used to generate reference squares for the sqrt datapath and to check sqrt results.
- Start/valid handshake matches the sqrt controller's.

Parameters:
- W, default 8: width of `root`; `square` is 2W bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- root  input  W  operand; captured on the edge that accepts `start`.
- busy  output  1  high in ACCUM and DONE.
- valid  output  1  one-cycle result strobe.
- square  output  2W  result; holds its value until the next completion.

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE, valid=0, busy=0, square=0, internal cnt/acc/odd=0. A reset mid-operation aborts the operation with no valid pulse.
- States: IDLE, ACCUM, DONE; encoding in package; all outputs registered.
- IDLE:
  - If start=1 at an edge: cnt<=root, acc<=0, odd<=1, go to ACCUM.
  - Otherwise stay in IDLE.
- ACCUM, each edge:
  - If cnt≠0: acc<=acc+odd, odd<=odd+2, cnt<=cnt−1.
  - If cnt==0: square<=acc, valid<=1, go to DONE.
- DONE: valid=1 for exactly this one cycle. The next edge sets valid<=0 and returns to IDLE.
- Latency: if start is accepted at edge k, valid is high in the cycle after edge k+root+1. root=0 gives valid after edge k+1.
- start in ACCUM or DONE is ignored and never queued. `root` changes while busy have no effect.
- Back-to-back: next start is accepted in the IDLE cycle after DONE. Minimum issue interval is root+3 cycles.
- Width rules:
  - acc and square: 2W bits, no overflow, since (2^W−1)² < 2^(2W).
  - odd: W+1 bits, maximum value 2^(W+1)−1.
  - cnt: W bits.

Optional Feature:
- Macro: INT_SQUARE_SHIFT_ADD_EN.
- Defined: ACCUM uses radix-2 shift-add.
  - On accept: mcand<=root (2W bits), mplier<=root, cnt<=W.
  - Each ACCUM step with cnt≠0: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt−=1.
  - Latency is fixed at W+1 edges, independent of root.
- Undefined: odd-sum algorithm as above. Data-dependent latency root+1 edges.
- Ports, states, handshake and reset behaviour are identical in both builds.

Decomposition:
- Package int_sqrt_pkg contains:
  - state enum {IDLE, ACCUM, DONE}
  - default W=8
  - function sq_ref(root), a reference model shared by both benches.
- Sub-module int_square_dp: cnt/acc/odd (or mcand/mplier) registers and adders, driven by load/step enables.
- int_square keeps the FSM, busy, valid and the square register.

Test Plan:
- W=8, root=0, start 1 cycle → valid after edge k+1, square=0; busy high 2 cycles.
- root=5 → square=25, valid one cycle after edge k+6; with SHIFT_ADD_EN, after edge k+9.
- root=255 → square=65025 (0xFE01), no overflow; valid exactly one cycle.
- root=12 accepted, then start held high with root=3 during busy → single result 144; no second valid until a new start in IDLE.
- clr_n pulsed low mid-ACCUM (root=200) → outputs immediately 0, state IDLE; then root=7 → 49.
- Back-to-back root=9 then 10 (second start in the IDLE cycle after DONE) → 81 then 100, square holding 81 between the pulses.

Source files
------------

// File: rtl/int_sqrt_pkg.sv
// Shared definitions for the integer square / square-root units.
//   W_DEFAULT : default operand width
//   state_t   : controller state encoding (IDLE, ACCUM, DONE)
//   sq_ref    : reference square, used by benches of both units
package int_sqrt_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  function automatic logic [63:0] sq_ref(input logic [31:0] r);
    return 64'(r) * 64'(r);
  endfunction

endpackage

// File: rtl/int_square_dp.sv
// Datapath for int_square: accumulator and iteration registers.
// Default build sums consecutive odd numbers (root+1 edge latency).
// With INT_SQUARE_SHIFT_ADD_EN defined, a radix-2 shift-add multiplier
// is used instead (fixed W+1 edge latency).
// Ports:
//   clk, clr_n  : clock, async active-low reset
//   load        : capture root and clear the accumulator
//   step        : perform one iteration
//   root        : operand
//   acc         : running sum / product (2W bits)
//   cnt_zero_c  : iteration counter has reached zero (combinational)
module int_square_dp
  import int_sqrt_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   root,
  output logic [2*W-1:0] acc,
  output logic           cnt_zero_c
);

  localparam int unsigned AW = 2 * W;

`ifdef INT_SQUARE_SHIFT_ADD_EN

  localparam int unsigned CW = $clog2(W + 1);

  logic [CW-1:0] cnt;
  logic [AW-1:0] mcand;
  logic [W-1:0]  mplier;

  // One multiplier bit per step, LSB first.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      cnt    <= CW'(W);
      acc    <= '0;
      mcand  <= AW'(root);
      mplier <= root;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

`else

  localparam int unsigned OW = W + 1;

  logic [W-1:0]  cnt;
  logic [OW-1:0] odd;

  // root^2 = 1 + 3 + ... + (2*root-1); odd never exceeds 2^(W+1)-1.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
      acc <= '0;
      odd <= '0;
    end else if (load) begin
      cnt <= root;
      acc <= '0;
      odd <= OW'(1);
    end else if (step) begin
      acc <= acc + AW'(odd);
      odd <= odd + OW'(2);
      cnt <= cnt - W'(1);
    end
  end

`endif

  assign cnt_zero_c = (cnt == '0);

endmodule

// File: rtl/int_square.sv
// Iterative integer squarer: square = root * root.
// Optional build macro: INT_SQUARE_SHIFT_ADD_EN (shift-add datapath,
// fixed latency); otherwise odd-number accumulation.
// Ports:
//   clk    : clock
//   clr_n  : async active-low reset; aborts any operation
//   start  : request, sampled only in IDLE
//   root   : operand, captured when start is accepted
//   busy   : high in ACCUM and DONE
//   valid  : one-cycle result strobe
//   square : result, held until the next completion
module int_square
  import int_sqrt_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           start,
  input  logic [W-1:0]   root,
  output logic           busy,
  output logic           valid,
  output logic [2*W-1:0] square
);

  state_t         state_q;
  state_t         state_d;
  logic           load_c;
  logic           step_c;
  logic           cnt_zero_c;
  logic [2*W-1:0] acc;

  int_square_dp #(.W(W)) u_dp (
    .clk        (clk),
    .clr_n      (clr_n),
    .load       (load_c),
    .step       (step_c),
    .root       (root),
    .acc        (acc),
    .cnt_zero_c (cnt_zero_c)
  );

  // Next-state and datapath enables.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (!cnt_zero_c) begin
          step_c = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; busy/valid follow the next state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      valid   <= 1'b0;
      square  <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == ST_ACCUM) || (state_d == ST_DONE);
      valid   <= (state_d == ST_DONE);
      if ((state_q == ST_ACCUM) && cnt_zero_c) begin
        square <= acc;
      end
    end
  end

endmodule

// File: tb/tb_int_square.sv
// Self-checking bench for int_square: table of roots with expected
// squares, scoreboard of expected results, plus corner-case sequences
// (held start, reset mid-operation, back-to-back issue).
module tb_int_square;
  import int_sqrt_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned W2 = 2 * W;

  logic          clk   = 1'b0;
  logic          clr_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  root  = '0;
  logic          busy;
  logic          valid;
  logic [W2-1:0] square;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W2-1:0] sb[$];

  typedef struct {
    logic [W-1:0]  r;
    logic [W2-1:0] exp_sq;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  int_square #(.W(W)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .root   (root),
    .busy   (busy),
    .valid  (valid),
    .square (square)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] r);
`ifdef INT_SQUARE_SHIFT_ADD_EN
    return int'(W) + 1;
`else
    return int'(r) + 1;
`endif
  endfunction

  // Scoreboard: every valid strobe must match the oldest outstanding request.
  always @(negedge clk) begin
    logic [W2-1:0] e;
    if (clr_n && valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got square %0d with no request pending at %0t", square, $time);
      end else begin
        e = sb.pop_front();
        check("square", 64'(square), 64'(e));
      end
    end
  end

  // Issue one request once idle; optionally keep start high with a new root while busy.
  task automatic run_one(input logic [W-1:0] r, input bit hold, input logic [W-1:0] r2);
    int  n;
    int  guard;
    bit  seen;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    root  = r;
    start = 1'b1;
    sb.push_back(W2'(sq_ref(32'(r))));
    @(posedge clk);
    #1;
    check("busy_after_accept", 64'(busy), 64'(1));
    if (hold) root = r2;
    else      start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      @(posedge clk);
      #1;
      n++;
      if (valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL valid_timeout: no valid within %0d cycles for root %0d", n, r);
      sb.delete();
    end else begin
      check("latency", 64'(n), 64'(exp_lat(r)));
      check("busy_at_valid", 64'(busy), 64'(1));
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check("valid_one_cycle", 64'(valid), 64'(0));
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  initial begin
    vecs[0] = '{8'd0,   16'd0};
    vecs[1] = '{8'd1,   16'd1};
    vecs[2] = '{8'd5,   16'd25};
    vecs[3] = '{8'd255, 16'hFE01};
    vecs[4] = '{8'd128, 16'd16384};
    vecs[5] = '{8'd254, 16'd64516};
    vecs[6] = '{8'd15,  16'd225};
    vecs[7] = '{8'd170, 16'd28900};
    for (int i = 8; i < 12; i++) begin
      vecs[i].r      = W'($urandom_range(0, 255));
      vecs[i].exp_sq = W2'(sq_ref(32'(vecs[i].r)));
    end

    // Reset values (asynchronous).
    #1;
    check("rst_busy",   64'(busy),   64'(0));
    check("rst_valid",  64'(valid),  64'(0));
    check("rst_square", 64'(square), 64'(0));
    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      run_one(vecs[i].r, 1'b0, '0);
      check("square_hold", 64'(square), 64'(vecs[i].exp_sq));
    end

    // start held high during busy with a different root: single result.
    run_one(8'd12, 1'b1, 8'd3);
    repeat (20) @(posedge clk);
    #1;
    check("held_start_idle", 64'(busy), 64'(0));
    check("held_start_square", 64'(square), 64'(144));

    // Reset mid-ACCUM aborts without a valid.
    @(negedge clk);
    root  = 8'd200;
    start = 1'b1;
    sb.push_back(W2'(sq_ref(32'd200)));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    clr_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy",   64'(busy),   64'(0));
    check("abort_valid",  64'(valid),  64'(0));
    check("abort_square", 64'(square), 64'(0));
    @(negedge clk);
    clr_n = 1'b1;
    run_one(8'd7, 1'b0, '0);
    check("after_abort_square", 64'(square), 64'(49));

    // Back-to-back: second start in the IDLE cycle right after DONE.
    run_one(8'd9, 1'b0, '0);
    check("b2b_hold_81", 64'(square), 64'(81));
    run_one(8'd10, 1'b0, '0);
    check("b2b_square_100", 64'(square), 64'(100));

    repeat (5) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
